router_out_arbiter: RTL and testbench

- Output-side scheduler for the 1x3 router: drains the three per-port output FIFOs onto one shared 8-bit egress bus.
- Grants ports in round-robin order and forwards whole packets (header, payload, parity) without interleaving.
- Drives each FIFO's read_enb_x from that FIFO's valid_out_x and data_out_x.
- Sits between router_top's output ports and a single downstream consumer.

---
 rtl/router_pkg.sv | 22 ++
 rtl/rr_arb3.sv | 31 +++
 rtl/router_out_arbiter.sv | 179 +++++++++++++++++
 tb/tb_router_out_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header layout for the router output arbiter.
package router_pkg;

    localparam int NUM_PORTS = 3;

    // Header byte layout: destination address in the low bits, payload length above it.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } arb_state_e;

    function automatic logic [1:0] wrap_inc3(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr, mod 3.
module rr_arb3
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic                 gnt_vld,
    output logic [1:0]           gnt_idx
);

    logic [1:0] cand_0;
    logic [1:0] cand_1;
    logic [1:0] cand_2;

    always_comb begin
        // An out-of-range pointer is treated as port 0.
        cand_0  = (ptr >= 2'd3) ? 2'd0 : ptr;
        cand_1  = wrap_inc3(cand_0);
        cand_2  = wrap_inc3(cand_1);
        gnt_vld = |req;
        gnt_idx = cand_0;
        if (req[cand_0]) begin
            gnt_idx = cand_0;
        end else if (req[cand_1]) begin
            gnt_idx = cand_1;
        end else if (req[cand_2]) begin
            gnt_idx = cand_2;
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Drains three packet FIFOs onto one egress bus, one whole packet per round-robin grant.
// Handshake: a FIFO pop is issued only when out_ready=1; the popped byte appears with out_valid one cycle later.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int DW        = 8,
    parameter int STALL_MAX = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_out_0,
    input  logic          valid_out_1,
    input  logic          valid_out_2,
    input  logic [DW-1:0] data_out_0,
    input  logic [DW-1:0] data_out_1,
    input  logic [DW-1:0] data_out_2,
    output logic          read_enb_0,
    output logic          read_enb_1,
    output logic          read_enb_2,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [1:0]    out_port,
    output logic          out_abort,
    output logic          hdr_err,
    output logic          arb_busy
);

    localparam logic [4:0] STALL_LAST = 5'(STALL_MAX - 1);

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [6:0] left_q, left_d;
    logic [4:0] stall_q, stall_d;

    logic          out_valid_q;
    logic          out_sop_q;
    logic          out_eop_q;
    logic          out_abort_q;
    logic [1:0]    out_port_q;

    logic          rd_req;
    logic          rd_en;
    logic          sop_d;
    logic          eop_d;
    logic          abort_d;
    logic          arb_vld;
    logic [1:0]    arb_idx;
    logic          gnt_valid;
    logic [DW-1:0] gnt_data;

    rr_arb3 u_rr_arb3 (
        .req     ({valid_out_2, valid_out_1, valid_out_0}),
        .ptr     (rr_ptr_q),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        case (grant_q)
            2'd0: begin
                gnt_valid = valid_out_0;
                gnt_data  = data_out_0;
            end
            2'd1: begin
                gnt_valid = valid_out_1;
                gnt_data  = data_out_1;
            end
            2'd2: begin
                gnt_valid = valid_out_2;
                gnt_data  = data_out_2;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_data  = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        left_d   = left_q;
        stall_d  = stall_q;
        rd_req   = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_ready && arb_vld) begin
                    rd_req   = 1'b1;
                    sop_d    = 1'b1;
                    grant_d  = arb_idx;
                    rr_ptr_d = wrap_inc3(arb_idx);
                    state_d  = HDR;
                end
            end
            HDR: begin
                // Header byte is on data_out now; remaining reads = payload + parity.
                left_d  = {1'b0, gnt_data[LEN_MSB:LEN_LSB]} + 7'd1;
                stall_d = '0;
                state_d = BODY;
            end
            BODY: begin
                if ((left_q != 7'd0) && out_ready) begin
                    if (gnt_valid) begin
                        rd_req  = 1'b1;
                        left_d  = left_q - 7'd1;
                        stall_d = '0;
                        if (left_q == 7'd1) begin
                            eop_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (stall_q == STALL_LAST) begin
                        abort_d = 1'b1;
                        stall_d = '0;
                        state_d = IDLE;
                    end else begin
                        stall_d = stall_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop during reset would lose a byte the FIFO still considers pending.
    assign rd_en      = rd_req & ~reset;
    assign read_enb_0 = rd_en && (grant_d == 2'd0);
    assign read_enb_1 = rd_en && (grant_d == 2'd1);
    assign read_enb_2 = rd_en && (grant_d == 2'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            left_q      <= '0;
            stall_q     <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_abort_q <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            left_q      <= left_d;
            stall_q     <= stall_d;
            out_valid_q <= rd_en;
            out_sop_q   <= sop_d;
            out_eop_q   <= eop_d;
            out_abort_q <= abort_d;
            if (sop_d) begin
                out_port_q <= grant_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_abort = out_abort_q;
    assign out_port  = out_port_q;
    assign out_data  = out_valid_q ? gnt_data : '0;
    assign hdr_err   = out_sop_q && (gnt_data[ADDR_MSB:ADDR_LSB] != grant_q);
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: FIFO models, a byte scoreboard and packet-level vectors.
`timescale 1ns/1ps
module tb_router_out_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid_out_0, valid_out_1, valid_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop, out_eop;
    logic [1:0] out_port;
    logic       out_abort, hdr_err, arb_busy;

    router_out_arbiter #(.DW(8), .STALL_MAX(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .valid_out_2 (valid_out_2),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .read_enb_0  (read_enb_0),
        .read_enb_1  (read_enb_1),
        .read_enb_2  (read_enb_2),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_port    (out_port),
        .out_abort   (out_abort),
        .hdr_err     (hdr_err),
        .arb_busy    (arb_busy)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // FIFO models: registered read data, valid while non-empty
    logic [7:0] mem [3][256];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};
    logic [7:0] dq [3] = '{8'h00, 8'h00, 8'h00};
    int         underflow_cnt = 0;
    logic [2:0] re;

    assign re          = {read_enb_2, read_enb_1, read_enb_0};
    assign valid_out_0 = (wp[0] != rp[0]);
    assign valid_out_1 = (wp[1] != rp[1]);
    assign valid_out_2 = (wp[2] != rp[2]);
    assign data_out_0  = dq[0];
    assign data_out_1  = dq[1];
    assign data_out_2  = dq[2];

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (re[i]) begin
                if (rp[i] != wp[i]) begin
                    dq[i] <= mem[i][rp[i] % 256];
                    rp[i] <= rp[i] + 1;
                end else begin
                    underflow_cnt <= underflow_cnt + 1;
                end
            end
        end
    end

    // Scoreboard state: {hdr_err, sop, eop, port, data}
    logic [12:0] exp_q[$];
    int          gap_q[$];
    int compared = 0, mismatched = 0;
    int cyc = 0, sop_cyc = 0, last_eop_cyc = 0, last_byte_cyc = 0, abort_cyc = 0;
    int span = 0, byte_cnt = 0, herr_cnt = 0, eop_cnt = 0, abort_cnt = 0;
    logic toggle_ready = 1'b0;

    typedef struct {
        int         port;
        logic [7:0] hdr;
        int         nbytes;
        int         herr;
        int         span;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: sample outputs at negedge, check, then optionally toggle out_ready.
    task automatic tick();
        logic [12:0] act;
        logic [12:0] e;
        @(negedge clock);
        cyc++;
        compared++;
        if ($countones(re) > 1 || (re != 3'b000 && !out_ready)) begin
            mismatched++;
            $display("FAIL read_strobe: read_enb=%b out_ready=%b, required at most one and only with out_ready",
                     re, out_ready);
        end
        if (out_valid) begin
            act = {hdr_err, out_sop, out_eop, out_port, out_data};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_byte: got %h with nothing expected", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL egress_byte: got herr/sop/eop/port/data=%b/%b/%b/%0d/%h expected %b/%b/%b/%0d/%h",
                             act[12], act[11], act[10], act[9:8], act[7:0], e[12], e[11], e[10], e[9:8], e[7:0]);
                end
            end
            byte_cnt++;
            last_byte_cyc = cyc;
            if (out_sop) begin
                gap_q.push_back(cyc - last_eop_cyc);
                sop_cyc = cyc;
            end
            if (hdr_err) herr_cnt++;
            if (out_eop) begin
                eop_cnt++;
                last_eop_cyc = cyc;
                span = cyc - sop_cyc;
            end
        end else begin
            compared++;
            if (out_sop || out_eop || hdr_err || out_data != 8'h00) begin
                mismatched++;
                $display("FAIL idle_bus: sop=%b eop=%b hdr_err=%b data=%h with out_valid=0, required all 0",
                         out_sop, out_eop, hdr_err, out_data);
            end
        end
        if (out_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (toggle_ready) out_ready = ~out_ready;
    endtask

    task automatic push_byte(input int p, input logic [7:0] b);
        mem[p][wp[p] % 256] = b;
        wp[p] = wp[p] + 1;
    endtask

    // Builds header + payload + XOR parity; pushes cut_fifo bytes and expects cut_exp (0 = all).
    task automatic load_pkt(input int p, input logic [7:0] hdr, input int cut_fifo, input int cut_exp);
        logic [7:0] bytes[$];
        logic [7:0] par;
        logic [7:0] b;
        int len, total, nf, ne;
        len   = int'(hdr[7:2]);
        total = len + 2;
        par   = hdr;
        bytes.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b   = 8'(p * 64 + i * 5 + 3);
            par = par ^ b;
            bytes.push_back(b);
        end
        bytes.push_back(par);
        nf = (cut_fifo == 0) ? total : cut_fifo;
        ne = (cut_exp == 0) ? total : cut_exp;
        for (int i = 0; i < nf; i++) push_byte(p, bytes[i]);
        for (int i = 0; i < ne; i++)
            exp_q.push_back({(i == 0) && (hdr[1:0] != 2'(p)), (i == 0), (i == total - 1), 2'(p), bytes[i]});
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || arb_busy) && n < max_cyc) begin
            tick();
            n++;
        end
        compared++;
        if (n >= max_cyc) begin
            mismatched++;
            $display("FAIL %s: timeout after %0d cycles, %0d bytes still expected", name, n, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"},  int'(out_data),  0);
        chk({tag, "_out_sop"},   int'(out_sop),   0);
        chk({tag, "_out_eop"},   int'(out_eop),   0);
        chk({tag, "_out_port"},  int'(out_port),  0);
        chk({tag, "_out_abort"}, int'(out_abort), 0);
        chk({tag, "_hdr_err"},   int'(hdr_err),   0);
        chk({tag, "_arb_busy"},  int'(arb_busy),  0);
        chk({tag, "_read_enb"},  int'(re),        0);
    endtask

    initial begin
        int e0, a0, n;
        vecs[0] = '{port: 1, hdr: 8'h0D, nbytes: 5,  herr: 0, span: 5};
        vecs[1] = '{port: 0, hdr: 8'h02, nbytes: 2,  herr: 1, span: 2};
        vecs[2] = '{port: 2, hdr: 8'h0A, nbytes: 4,  herr: 0, span: 4};
        vecs[3] = '{port: 0, hdr: 8'hFC, nbytes: 65, herr: 0, span: 65};
        vecs[4] = '{port: 1, hdr: 8'h00, nbytes: 2,  herr: 1, span: 2};

        // Reset state
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single-packet vectors
        for (int v = 0; v < 5; v++) begin
            byte_cnt = 0;
            herr_cnt = 0;
            e0 = eop_cnt;
            load_pkt(vecs[v].port, vecs[v].hdr, 0, 0);
            wait_done(300, "vec_done");
            chk("vec_bytes", byte_cnt, vecs[v].nbytes);
            chk("vec_hdr_err", herr_cnt, vecs[v].herr);
            chk("vec_span", span, vecs[v].span);
            chk("vec_eop_count", eop_cnt - e0, 1);
        end

        // All three ports pending at reset release: grants 0,1,2, back-to-back
        reset = 1'b1;
        tick();
        load_pkt(0, 8'h08, 0, 0);
        load_pkt(1, 8'h09, 0, 0);
        load_pkt(2, 8'h0A, 0, 0);
        tick();
        reset = 1'b0;
        gap_q.delete();
        wait_done(100, "rr_three_done");
        load_pkt(0, 8'h08, 0, 0);
        load_pkt(2, 8'h0A, 0, 0);
        wait_done(100, "rr_wrap_done");
        chk("rr_sop_count", gap_q.size(), 5);
        if (gap_q.size() == 5) begin
            chk("rr_gap_1", gap_q[1], 1);
            chk("rr_gap_2", gap_q[2], 1);
            chk("rr_gap_4", gap_q[4], 1);
        end

        // Starved mid-payload: abort after 16 starved cycles, no eop
        e0 = eop_cnt;
        a0 = abort_cnt;
        load_pkt(2, 8'h16, 3, 3);
        n = 0;
        while (abort_cnt == a0 && n < 60) begin
            tick();
            n++;
        end
        chk("abort_seen", abort_cnt - a0, 1);
        chk("abort_delay", abort_cyc - last_byte_cyc, 16);
        chk("abort_busy", int'(arb_busy), 0);
        chk("abort_no_eop", eop_cnt - e0, 0);
        chk("abort_drained", exp_q.size(), 0);
        tick();
        chk("abort_pulse_len", int'(out_abort), 0);
        chk("abort_busy_after", int'(arb_busy), 0);
        // Pointer stayed at 0 after granting 2 and aborting: port 0 wins over port 1
        load_pkt(0, 8'h08, 0, 0);
        load_pkt(1, 8'h09, 0, 0);
        wait_done(100, "abort_recover_done");

        // out_ready toggling during a len-5 packet
        a0 = abort_cnt;
        byte_cnt = 0;
        out_ready = 1'b1;
        toggle_ready = 1'b1;
        load_pkt(1, 8'h15, 0, 0);
        wait_done(100, "ready_toggle_done");
        toggle_ready = 1'b0;
        out_ready = 1'b1;
        chk("toggle_bytes", byte_cnt, 7);
        chk("toggle_span", span, 12);
        chk("toggle_no_abort", abort_cnt - a0, 0);

        // Reset while in BODY with left=3
        byte_cnt = 0;
        load_pkt(0, 8'h10, 0, 3);
        repeat (4) tick();
        chk("mid_busy", int'(arb_busy), 1);
        reset = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        chk("mid_bytes", byte_cnt, 3);
        wp[0] = rp[0];
        tick();
        reset = 1'b0;
        load_pkt(0, 8'h08, 0, 0);
        load_pkt(1, 8'h09, 0, 0);
        wait_done(100, "post_reset_done");

        chk("fifo_underflow", underflow_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
